// File: rtl/loader_pkg.sv
// Shared constants and entry type for the iNES loader write path.
// Holds SDRAM address layout and the FIFO entry layout {addr, data}.
package loader_pkg;

  localparam int LOADER_ADDR_W = 22;
  localparam int LOADER_DEPTH_LOG2 = 2;

  localparam logic [LOADER_ADDR_W-1:0] CHR_BASE = 22'h200000;

  typedef struct packed {
    logic [LOADER_ADDR_W-1:0] addr;
    logic [7:0]               data;
  } loader_entry_t;

endpackage

// File: rtl/loader_write_queue_if.sv
// Byte write bus: strobe/write-enable plus address and data.
// master drives we/addr/data, slave samples them.
interface loader_write_queue_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;

  modport master (
    output we,
    output addr,
    output data
  );

  modport slave (
    input we,
    input addr,
    input data
  );

endinterface

// File: rtl/loader_fifo.sv
// Generic synchronous FIFO, power-of-two depth, show-ahead head output.
// Ports: clk, reset, push/din, pop/dout, full, empty, count.
module loader_fifo #(
  parameter int WIDTH      = 30,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // A pop frees the head slot first, so a push into a full
  // FIFO is still accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/loader_write_queue.sv
// Queues loader ROM bytes and issues one SDRAM write per slot strobe.
// Ports: clk, reset, in_bus (loader side, slave), slot, mem_bus
// (SDRAM side, master), busy, count, overflow (sticky), and checksum
// when LOADER_QUEUE_CHECKSUM_EN is defined.
module loader_write_queue
  import loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = LOADER_DEPTH_LOG2,
  parameter int ADDR_W     = LOADER_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  loader_write_queue_if.slave   in_bus,
  input  logic                  slot,
  loader_write_queue_if.master  mem_bus,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   count,
`ifdef LOADER_QUEUE_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  overflow
);

  loader_entry_t         in_entry;
  loader_entry_t         head;
  logic                  full;
  logic                  empty;
  logic                  issue;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [7:0]            data_q;

  assign in_entry.addr = in_bus.addr;
  assign in_entry.data = in_bus.data;

  // Empty is the pre-edge state, so a byte pushed on a slot
  // cycle waits for the next slot.
  assign issue = slot & ~empty;

  loader_fifo #(
    .WIDTH      ($bits(loader_entry_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_bus.we),
    .din   (in_entry),
    .pop   (slot),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (slot) begin
      we_q <= issue;
      if (issue) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end
    end
  end

  // Full with a slot pops first, so only an unpaired push drops.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (in_bus.we & full & ~slot)
      overflow <= 1'b1;
  end

`ifdef LOADER_QUEUE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)
      checksum <= '0;
    else if (issue)
      checksum <= checksum + {8'h00, head.data};
  end
`endif

  assign mem_bus.we   = we_q;
  assign mem_bus.addr = addr_q;
  assign mem_bus.data = data_q;

  assign busy = (count != '0) | we_q;

endmodule
